// File: rtl/morse_letter_tx_if.sv
// Letter-in / serial-out bundle for morse_letter_tx.
// master drives letters toward the transmitter; slave is the transmitter.
interface morse_letter_tx_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) ();
    logic [WIDTH-1:0]         letter;
    logic                     done;
    logic                     tx;
    logic                     busy;
    logic [$clog2(DEPTH):0]   fill;
    logic                     overflow;

    modport master (
        output letter, done,
        input  tx, busy, fill, overflow
    );

    modport slave (
        input  letter, done,
        output tx, busy, fill, overflow
    );
endinterface

// File: rtl/morse_letter_tx.sv
// Queues decoded Morse letters and sends them as UART frames on tx.
// Define MORSE_TX_PARITY_EN to add an even-parity bit before the stop bit.
module morse_letter_tx #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic             clk,
    input  logic             reset,
    morse_letter_tx_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [FW-1:0] FULL   = FW'(DEPTH);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] B_LAST = CW'(WIDTH - 1);

`ifdef MORSE_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    bit_q, bit_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
`ifdef MORSE_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic capture;
    logic pop;
    logic accept;
    logic tick;

    always_comb begin
        state_d    = state_q;
        done_d     = bus.done;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        overflow_d = overflow_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        timer_d    = timer_q + 1'b1;
        tx_d       = tx_q;
        busy_d     = busy_q;
`ifdef MORSE_TX_PARITY_EN
        par_d      = par_q;
`endif

        capture = bus.done & ~done_q;
        pop     = (state_q == IDLE) && (fill_q != '0);
        accept  = capture && ((fill_q != FULL) || pop);
        tick    = (timer_q == T_LAST);

        if (accept) begin
            mem_d[wr_ptr_q] = bus.letter;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end else if (capture) begin
            overflow_d = 1'b1;
        end

        if (accept && !pop)
            fill_d = fill_q + 1'b1;
        else if (pop && !accept)
            fill_d = fill_q - 1'b1;

        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (pop) begin
                    shift_d  = mem_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    bit_d    = '0;
                    state_d  = START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
`ifdef MORSE_TX_PARITY_EN
                    par_d    = ^mem_q[rd_ptr_q];
`endif
                end
            end
            START: begin
                if (tick) begin
                    timer_d = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    timer_d = '0;
                    if (bit_q == B_LAST) begin
`ifdef MORSE_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
`ifdef MORSE_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    timer_d = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    timer_d = '0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            state_q    <= IDLE;
            done_q     <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
            shift_q    <= '0;
            bit_q      <= '0;
            timer_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef MORSE_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            timer_q    <= timer_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
`ifdef MORSE_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.fill     = fill_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_morse_letter_tx.sv
// Bench for morse_letter_tx: directed scenarios plus random traffic,
// every cycle compared against a frame-level queue model.
module tb_morse_letter_tx;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
`ifdef MORSE_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB  = WIDTH + 2 + PAR;
    localparam int FL  = NB * CPB;
    localparam int FW  = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    morse_letter_tx_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    morse_letter_tx #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Reference: pending letters, the frame on the wire, and its cycle index.
    int unsigned    mq[$];
    logic [NB-1:0]  fr;
    int             pos;
    bit             prev_done;
    bit             m_ovf;

    int cyc = 0;
    int rise_t[$];
    logic busy_prev = 1'b0;
    int max_fill;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit idle;
        int unsigned l;
        if (reset) begin
            mq.delete();
            pos = -1;
            prev_done = 1'b1;
            m_ovf = 1'b0;
        end else begin
            idle = (pos < 0);
            if (!idle) begin
                pos++;
                if (pos == FL) pos = -1;
            end
            if (idle && mq.size() > 0) begin
                l = mq.pop_front();
`ifdef MORSE_TX_PARITY_EN
                fr = {1'b1, ^l[WIDTH-1:0], l[WIDTH-1:0], 1'b0};
`else
                fr = {1'b1, l[WIDTH-1:0], 1'b0};
`endif
                pos = 0;
            end
            if (bus.done && !prev_done) begin
                if (mq.size() < DEPTH) mq.push_back(int'(bus.letter));
                else m_ovf = 1'b1;
            end
            prev_done = bus.done;
        end
    endtask

    task automatic step();
        logic etx;
        @(posedge clk);
        model_edge();
        #1;
        etx = (pos < 0) ? 1'b1 : fr[pos / CPB];
        chk("tx", 32'(bus.tx), 32'(etx));
        chk("busy", 32'(bus.busy), 32'(pos >= 0));
        chk("fill", 32'(bus.fill), 32'(mq.size()));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        if (bus.busy === 1'b1 && busy_prev !== 1'b1) rise_t.push_back(cyc);
        busy_prev = bus.busy;
        if (int'(bus.fill) > max_fill) max_fill = int'(bus.fill);
        cyc++;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(logic [WIDTH-1:0] l);
        bus.letter = l;
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        step();
    endtask

    int busy_cnt;

    initial begin
        reset = 1'b1;
        bus.done = 1'b1;
        bus.letter = 8'h00;
        pos = -1;
        prev_done = 1'b1;
        m_ovf = 1'b0;

        // reset with done held high
        steps(2);
        chk("rst_tx", 32'(bus.tx), 32'd1);
        chk("rst_fill", 32'(bus.fill), 32'd0);
        reset = 1'b0;
        steps(5);
        chk("no_capture_held", 32'(bus.fill), 32'd0);
        bus.done = 1'b0;
        steps(2);

        // single letter
        rise_t.delete();
        busy_cnt = 0;
        bus.letter = 8'h53;
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        for (int i = 0; i < FL + 10; i++) begin
            step();
            if (bus.busy === 1'b1) busy_cnt++;
        end
        chk("single_busy_len", 32'(busy_cnt), 32'(FL));
        chk("single_frames", 32'(rise_t.size()), 32'd1);

        // held level
        rise_t.delete();
        max_fill = 0;
        bus.letter = 8'h45;
        bus.done = 1'b1;
        steps(66);
        bus.done = 1'b0;
        steps(20);
        chk("held_frames", 32'(rise_t.size()), 32'd1);
        chk("held_peak_fill", 32'(max_fill), 32'd1);

        // overflow
        rise_t.delete();
        max_fill = 0;
        chk("pre_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 6; i++) pulse(8'(8'h41 + i));
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        chk("ovf_peak_fill", 32'(max_fill), 32'(DEPTH));
        steps(6 * (FL + 1));
        chk("ovf_frames", 32'(rise_t.size()), 32'd5);

        // back-to-back
        rise_t.delete();
        pulse(8'h00);
        pulse(8'hFF);
        steps(2 * FL + 10);
        chk("b2b_frames", 32'(rise_t.size()), 32'd2);
        if (rise_t.size() >= 2)
            chk("b2b_gap", 32'(rise_t[1] - rise_t[0]), 32'(FL + 1));

        // mid-frame reset during data bit 3 with another letter queued
        pulse(8'hA5);
        pulse(8'h3C);
        for (int i = 0; i < 40 && pos != 17; i++) step();
        chk("mid_pos", 32'(pos), 32'd17);
        reset = 1'b1;
        step();
        chk("mid_rst_tx", 32'(bus.tx), 32'd1);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_fill", 32'(bus.fill), 32'd0);
        reset = 1'b0;
        rise_t.delete();
        steps(60);
        chk("mid_no_frame", 32'(rise_t.size()), 32'd0);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            bus.letter = 8'($urandom);
            bus.done = ($urandom_range(0, 5) == 0);
            step();
        end
        bus.done = 1'b0;
        steps((DEPTH + 1) * (FL + 1) + 5);
        chk("rand_drained", 32'(bus.fill), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
